serv_dbus_master: RTL and testbench

SERV_DBUS_MASTER -- requirements
Module: serv_dbus_master

---
 rtl/serv_dbus_pkg.sv | 27 ++
 rtl/serv_dbus_timer.sv | 67 ++++++
 rtl/serv_dbus_master.sv | 145 ++++++++++++++
 tb/tb_serv_dbus_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serv_dbus_pkg.sv
// -----------------------------------------------------------------------------
// serv_dbus_pkg
// Shared definitions for the SERV data-bus Wishbone master:
//   - dbus_state_e : 2-bit FSM state encoding (IDLE, BUS, DONE)
//   - ADR_W/DAT_W/SEL_W : Wishbone address, data and byte-select widths
//   - word_align() : clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package serv_dbus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } dbus_state_e;

  // The bus is word addressed; lane selection is carried by sel instead.
  localparam logic [ADR_W-1:0] ADR_WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [ADR_W-1:0] word_align(input logic [ADR_W-1:0] adr);
    return adr & ADR_WORD_MASK;
  endfunction

endpackage

// File: rtl/serv_dbus_timer.sv
// -----------------------------------------------------------------------------
// serv_dbus_timer
// Saturating bus-wait counter with a registered match flag.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   clr_i    : clear the count (takes priority over en_i)
//   en_i     : count one more wait cycle
//   match_o  : high while the count equals TIMEOUT (never when TIMEOUT = 0)
// TIMEOUT must fit in TW bits.
// -----------------------------------------------------------------------------
module serv_dbus_timer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic match_o
);

  localparam logic [TW-1:0] LIMIT    = TW'(TIMEOUT);
  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          match_q, match_d;

  // Next count: clear wins, otherwise step while enabled and below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match is computed from the next count so it is valid in the same cycle
  // the count register shows TIMEOUT.
  always_comb begin
    match_d = 1'b0;
    if (LIMIT != CNT_ZERO) begin
      match_d = (cnt_d == LIMIT);
    end else begin
      match_d = 1'b0;
    end
  end

  // Count and match registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= CNT_ZERO;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/serv_dbus_master.sv
// -----------------------------------------------------------------------------
// serv_dbus_master
// Single-outstanding Wishbone data-bus master for the SERV core.
// A core request in IDLE is latched and presented on the bus (BUS) until the
// slave acks, errors, or the wait timeout expires; a one-cycle DONE then
// reports o_ack (and o_err on fault) back to the core.
// Ports:
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_req, i_we, i_adr, i_dat, i_sel : core request (sampled only in IDLE)
//   o_wb_cyc/stb/we/adr/dat/sel : Wishbone master outputs (all registered)
//   i_wb_ack, i_wb_err, i_wb_rdt: Wishbone slave response
//   o_rdt                       : last successfully loaded word
//   o_ack, o_err                : completion / fault pulse during DONE
//   o_busy                      : high whenever not IDLE
// Parameters: TIMEOUT wait cycles before abort (0 = never), TW counter width.
// -----------------------------------------------------------------------------
module serv_dbus_master
  import serv_dbus_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [ADR_W-1:0] i_adr,
  input  logic [DAT_W-1:0] i_dat,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [DAT_W-1:0] o_wb_dat,
  output logic [SEL_W-1:0] o_wb_sel,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [DAT_W-1:0] i_wb_rdt,
  output logic [DAT_W-1:0] o_rdt,
  output logic             o_ack,
  output logic             o_err,
  output logic             o_busy
);

  dbus_state_e      state_q;
  logic             we_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [SEL_W-1:0] sel_q;
  logic             cyc_q;
  logic             ack_q;
  logic             err_q;
  logic             busy_q;
  logic [DAT_W-1:0] rdt_q;

  logic tmr_clr_s;
  logic tmr_en_s;
  logic tmr_match_s;

  // The counter restarts on the request that opens a bus cycle and counts
  // only cycles in which the slave has not yet answered.
  assign tmr_clr_s = (state_q == ST_IDLE) && i_req;
  assign tmr_en_s  = (state_q == ST_BUS) && !i_wb_ack && !i_wb_err;

  serv_dbus_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .clr_i   (tmr_clr_s),
    .en_i    (tmr_en_s),
    .match_o (tmr_match_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= {ADR_W{1'b0}};
      dat_q   <= {DAT_W{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdt_q   <= {DAT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (i_req) begin
            we_q    <= i_we;
            adr_q   <= word_align(i_adr);
            dat_q   <= i_dat;
            sel_q   <= i_sel;
            cyc_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (i_wb_ack || i_wb_err || tmr_match_s) begin
            cyc_q   <= 1'b0;
            ack_q   <= 1'b1;
            // Fault on slave error, or on timeout when no ack arrived;
            // an ack in the timeout cycle still completes cleanly.
            err_q   <= i_wb_err || !i_wb_ack;
            if (i_wb_ack && !i_wb_err && !we_q) begin
              rdt_q <= i_wb_rdt;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = cyc_q;
  assign o_wb_we  = we_q;
  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = sel_q;
  assign o_rdt    = rdt_q;
  assign o_ack    = ack_q;
  assign o_err    = err_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_serv_dbus_master.sv
// -----------------------------------------------------------------------------
// tb_serv_dbus_master
// Self-checking bench for serv_dbus_master (TIMEOUT = 4). The bench plays the
// Wishbone slave and predicts each transaction from its description: the
// response kind, the wait k, and the timeout rule decide how long cyc stays
// high, whether o_err is set and whether o_rdt takes the returned word.
// -----------------------------------------------------------------------------
module tb_serv_dbus_master;

  localparam int TO = 4;

  // response kinds
  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_adr;
  logic [31:0] i_dat;
  logic [3:0]  i_sel;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] i_wb_rdt;
  logic [31:0] o_rdt;
  logic        o_ack, o_err, o_busy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdt = 32'h0;

  serv_dbus_master #(.TIMEOUT(TO), .TW(8)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_adr    (i_adr),
    .i_dat    (i_dat),
    .i_sel    (i_sel),
    .o_wb_cyc (o_wb_cyc),
    .o_wb_stb (o_wb_stb),
    .o_wb_we  (o_wb_we),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_sel (o_wb_sel),
    .i_wb_ack (i_wb_ack),
    .i_wb_err (i_wb_err),
    .i_wb_rdt (i_wb_rdt),
    .o_rdt    (o_rdt),
    .o_ack    (o_ack),
    .o_err    (o_err),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One complete transaction. Called and returns on a falling edge.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int k, input int kind,
                         input bit hold_req, input logic [31:0] rdt_ack);
    int          cyc_cnt;
    int          end_idx;
    bit          timed_out;
    logic        exp_err;
    logic [31:0] exp_adr;
    timed_out = (kind == K_SILENT) || (k > TO);
    end_idx   = timed_out ? TO : k;
    exp_err   = timed_out || (kind == K_ERR) || (kind == K_BOTH);
    exp_adr   = adr & 32'hFFFF_FFFC;
    cyc_cnt   = 0;

    i_req = 1'b1; i_we = we; i_adr = adr; i_dat = dat; i_sel = sel;
    @(negedge i_clk);
    i_req = hold_req;
    if (hold_req) begin
      i_we = ~we; i_adr = $urandom; i_dat = $urandom; i_sel = 4'($urandom);
    end
    for (int t = 0; t < 32; t++) begin
      if (!o_wb_cyc) break;
      cyc_cnt++;
      check_eq("stb", {31'h0, o_wb_stb}, 32'h1);
      check_eq("we", {31'h0, o_wb_we}, {31'h0, we});
      check_eq("adr", o_wb_adr, exp_adr);
      check_eq("dat", o_wb_dat, dat);
      check_eq("sel", {28'h0, o_wb_sel}, {28'h0, sel});
      check_eq("busy_bus", {31'h0, o_busy}, 32'h1);
      check_eq("ack_in_bus", {31'h0, o_ack}, 32'h0);
      i_wb_rdt = ((cyc_cnt - 1) == k) ? rdt_ack : $urandom;
      i_wb_ack = ((kind == K_ACK) || (kind == K_BOTH)) && ((cyc_cnt - 1) == k);
      i_wb_err = ((kind == K_ERR) || (kind == K_BOTH)) && ((cyc_cnt - 1) == k);
      @(negedge i_clk);
    end
    if (!timed_out && (kind == K_ACK) && !we) model_rdt = rdt_ack;

    // DONE cycle; a stray ack here must be ignored
    i_req = 1'b0;
    i_wb_err = 1'b0;
    i_wb_ack = 1'($urandom_range(0, 1));
    i_wb_rdt = $urandom;
    check_eq("cyc_len", cyc_cnt, end_idx + 1);
    check_eq("cyc_done", {31'h0, o_wb_cyc}, 32'h0);
    check_eq("ack_done", {31'h0, o_ack}, 32'h1);
    check_eq("err_done", {31'h0, o_err}, {31'h0, exp_err});
    check_eq("busy_done", {31'h0, o_busy}, 32'h1);
    check_eq("rdt_done", o_rdt, model_rdt);
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    check_eq("ack_idle", {31'h0, o_ack}, 32'h0);
    check_eq("err_idle", {31'h0, o_err}, 32'h0);
    check_eq("busy_idle", {31'h0, o_busy}, 32'h0);
    check_eq("cyc_idle", {31'h0, o_wb_cyc}, 32'h0);
    check_eq("rdt_idle", o_rdt, model_rdt);
  endtask

  // A slave response while idle must not start or complete anything.
  task automatic stray_idle;
    i_wb_ack = 1'b1;
    i_wb_err = 1'($urandom_range(0, 1));
    i_wb_rdt = $urandom;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    check_eq("stray_ack", {31'h0, o_ack}, 32'h0);
    check_eq("stray_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check_eq("stray_busy", {31'h0, o_busy}, 32'h0);
    check_eq("stray_rdt", o_rdt, model_rdt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_adr = 32'h0; i_dat = 32'h0;
    i_sel = 4'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rdt = 32'h0;
    repeat (3) @(negedge i_clk);
    check_eq("rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check_eq("rst_stb", {31'h0, o_wb_stb}, 32'h0);
    check_eq("rst_we", {31'h0, o_wb_we}, 32'h0);
    check_eq("rst_ack", {31'h0, o_ack}, 32'h0);
    check_eq("rst_err", {31'h0, o_err}, 32'h0);
    check_eq("rst_busy", {31'h0, o_busy}, 32'h0);
    check_eq("rst_sel", {28'h0, o_wb_sel}, 32'h0);
    check_eq("rst_adr", o_wb_adr, 32'h0);
    check_eq("rst_dat", o_wb_dat, 32'h0);
    check_eq("rst_rdt", o_rdt, 32'h0);

    // request presented as reset releases is taken on the very next edge
    i_rst_n = 1'b1;
    run_txn(1'b0, 32'h0000_1003, 32'h0, 4'b1000, 2, K_ACK, 1'b0, 32'hDEAD_BEEF);
    check_eq("load_rdt", o_rdt, 32'hDEAD_BEEF);
    run_txn(1'b1, 32'h0000_2000, 32'h1122_3344, 4'b1111, 0, K_ACK, 1'b0, 32'h0BAD_F00D);
    check_eq("store_keeps_rdt", o_rdt, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_3000, 32'h0, 4'b0011, 0, K_SILENT, 1'b0, 32'h0);
    run_txn(1'b0, 32'h0000_4000, 32'h0, 4'b1111, 1, K_BOTH, 1'b0, 32'h5555_5555);
    check_eq("both_keeps_rdt", o_rdt, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_5000, 32'h0, 4'b1111, TO, K_ACK, 1'b0, 32'h600D_CAFE);
    stray_idle();
    run_txn(1'b0, 32'h0000_6004, 32'h0, 4'b0001, 1, K_ACK, 1'b1, 32'hCAFE_0001);

    // reset during BUS
    i_req = 1'b1; i_we = 1'b0; i_adr = 32'h0000_7000; i_sel = 4'hF;
    @(negedge i_clk);
    i_req = 1'b0;
    check_eq("pre_rst_cyc", {31'h0, o_wb_cyc}, 32'h1);
    i_rst_n = 1'b0;
    #1;
    model_rdt = 32'h0;
    check_eq("midrst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check_eq("midrst_stb", {31'h0, o_wb_stb}, 32'h0);
    check_eq("midrst_busy", {31'h0, o_busy}, 32'h0);
    check_eq("midrst_rdt", o_rdt, 32'h0);
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    check_eq("midrst_ack", {31'h0, o_ack}, 32'h0);
    i_rst_n = 1'b1;
    run_txn(1'b0, 32'h0000_7000, 32'h0, 4'hF, 1, K_ACK, 1'b0, 32'h1234_5678);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) stray_idle();
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, TO + 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
